// File: rtl/spi_cmd_sequencer.sv
// Sequences one command byte through an SPI peripheral core: setup, start, drain, response.
// All outputs are registered; they are decoded from the next state and latched on the same edge as the state.
module spi_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic [7:0]  seq_cmd_i,
  input  logic [4:0]  seq_cfg_i,
  input  logic        seq_cmd_valid_i,
  output logic        seq_cmd_ready_o,
  output logic [15:0] seq_rsp_o,
  output logic        seq_rsp_err_o,
  output logic        seq_rsp_valid_o,
  input  logic        seq_rsp_ready_i,
  output logic        seq_busy_o,
  output logic [7:0]  spi_data_o,
  output logic [5:0]  spi_statusreg_o,
  input  logic [15:0] spi_data_i,
  input  logic        spi_doneflag_i
);

  typedef enum logic [2:0] {IDLE, SETUP, START, DRAIN, RESP} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [4:0]  cfg_q, cfg_d;
  logic [15:0] rsp_q, rsp_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic [5:0]  status_q, status_d;

  logic accept;
  logic cnt_expired;

  assign accept      = seq_cmd_valid_i & ready_q;
  assign cnt_expired = (cnt_q == CNT_LAST);

  // State and registered outputs
  always_ff @(posedge spi_clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (spi_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      cfg_q    <= '0;
      rsp_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      cfg_q    <= cfg_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      status_q <= status_d;
    end
  end

  // Next-state logic; done outranks the START timeout
  always_comb begin
    // NOTE: a default on every path keeps this purely combinational (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (cnt_q == 16'd1) state_d = START;
      START: if (spi_doneflag_i || cnt_expired) state_d = DRAIN;
      DRAIN: if (!spi_doneflag_i || cnt_expired) state_d = RESP;
      RESP:  if (seq_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output decode
  always_comb begin
    cmd_d = cmd_q;
    cfg_d = cfg_q;
    rsp_d = rsp_q;
    err_d = err_q;

    if (state_q == IDLE && accept) begin
      cmd_d = seq_cmd_i;
      cfg_d = seq_cfg_i;
    end

    if (state_q == START) begin
      if (spi_doneflag_i) begin
        rsp_d = spi_data_i;
        err_d = 1'b0;
      end else if (cnt_expired) begin
        rsp_d = '0;
        err_d = 1'b1;
      end
    end

    // A done flag stuck high through the whole drain window flags the response, keeping its data
    if (state_q == DRAIN && spi_doneflag_i && cnt_expired) err_d = 1'b1;

    if (state_d == IDLE || state_d == RESP || state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);

    unique case (state_d)
      IDLE:    status_d = '0;
      START:   status_d = {cfg_d, 1'b1};
      default: status_d = {cfg_d, 1'b0};
    endcase
  end

  assign seq_cmd_ready_o = ready_q;
  assign seq_rsp_o       = rsp_q;
  assign seq_rsp_err_o   = err_q;
  assign seq_rsp_valid_o = valid_q;
  assign seq_busy_o      = busy_q;
  assign spi_data_o      = cmd_q;
  assign spi_statusreg_o = status_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: directed corner cases plus randomized transactions
// predicted cycle-by-cycle from a done-flag waveform description.
module tb_spi_cmd_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_i = '0;
  logic [4:0]  cfg_i = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] rsp;
  logic        rsp_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        busy;
  logic [7:0]  spi_data_o;
  logic [5:0]  status;
  logic [15:0] spi_data_i = '0;
  logic        done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .spi_clk_i       (clk),
    .spi_rst_i       (rst),
    .seq_cmd_i       (cmd_i),
    .seq_cfg_i       (cfg_i),
    .seq_cmd_valid_i (cmd_valid),
    .seq_cmd_ready_o (cmd_ready),
    .seq_rsp_o       (rsp),
    .seq_rsp_err_o   (rsp_err),
    .seq_rsp_valid_o (rsp_valid),
    .seq_rsp_ready_i (rsp_ready),
    .seq_busy_o      (busy),
    .spi_data_o      (spi_data_o),
    .spi_statusreg_o (status),
    .spi_data_i      (spi_data_i),
    .spi_doneflag_i  (done)
  );

  // One transaction, starting at a negedge in IDLE (that cycle is cycle 0).
  // done is high during START-relative cycles [d, d+h); setup_pulse raises it in cycles 1-2;
  // rd is the number of RESP cycles with rsp_ready low.
  task automatic run_txn(input string name, input logic [7:0] cmd, input logic [4:0] cfg,
                         input logic [15:0] data, input int d_in, input int h,
                         input bit setup_pulse, input int rd);
    int d, s, l, resp_c, last_c, r;
    bit exp_err, exp_start, dn;
    logic [15:0] exp_rsp;
    d = (h == 0) ? 100000 : d_in;
    // Reference model: length of START (s) and DRAIN (l), final response and error
    if (d < T) begin
      s = d + 1; exp_err = 1'b0; exp_rsp = data;
    end else begin
      s = T; exp_err = 1'b1; exp_rsp = 16'h0000;
    end
    l = T;
    for (int i = 0; i < T; i++) begin
      r  = s + i;
      dn = (r >= d) && (r < d + h);
      if (!dn) begin
        l = i + 1;
        break;
      end
      if (i == T - 1) exp_err = 1'b1;
    end
    resp_c = 3 + s + l;
    last_c = resp_c + rd;

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s c0 cmd_ready: got %b expected 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_i = cmd; cfg_i = cfg; done = 1'b0; rsp_ready = 1'b0;

    for (int c = 1; c <= last_c + 1; c++) begin
      @(negedge clk);
      if (c <= last_c) begin
        exp_start = (c >= 3) && (c < 3 + s);
        checks++;
        if (spi_data_o !== cmd) begin
          errors++; $display("FAIL %s c%0d spi_data: got %h expected %h", name, c, spi_data_o, cmd);
        end
        if (c < resp_c) begin
          checks++;
          if (status !== {cfg, exp_start}) begin
            errors++; $display("FAIL %s c%0d status: got %b expected %b", name, c, status, {cfg, exp_start});
          end
        end
        checks++;
        if (rsp_valid !== (c >= resp_c) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
          errors++; $display("FAIL %s c%0d valid/busy/ready: got %b%b%b expected %b10",
                             name, c, rsp_valid, busy, cmd_ready, c >= resp_c);
        end
        if (c >= resp_c) begin
          checks++;
          if (rsp !== exp_rsp || rsp_err !== exp_err) begin
            errors++; $display("FAIL %s c%0d rsp/err: got %h/%b expected %h/%b",
                               name, c, rsp, rsp_err, exp_rsp, exp_err);
          end
        end
      end else begin
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
          errors++; $display("FAIL %s idle valid/busy/ready: got %b%b%b expected 001",
                             name, rsp_valid, busy, cmd_ready);
        end
      end
      // Inputs for cycle c; stray command requests while busy must be ignored
      cmd_valid  = (c <= last_c) ? 1'($urandom) : 1'b0;
      cmd_i      = 8'($urandom);
      cfg_i      = 5'($urandom);
      if (c > last_c)  done = 1'b0;
      else if (c < 3)  done = setup_pulse;
      else             done = (c - 3 >= d) && (c - 3 < d + h);
      spi_data_i = (c - 3 == d) ? data : 16'($urandom);
      rsp_ready  = (c == last_c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (status !== 6'h00 || spi_data_o !== 8'h00 || rsp !== 16'h0000 ||
        rsp_err !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset outputs: got st=%b d=%h rsp=%h err=%b v=%b busy=%b rdy=%b expected all zero",
                         status, spi_data_o, rsp, rsp_err, rsp_valid, busy, cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset release ready/busy: got %b/%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_nominal();
    run_txn("nominal", 8'hA8, 5'b01011, 16'h3C5A, 10, 1, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout", 8'h5E, 5'b10100, 16'hBEEF, 0, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 8'h17, 5'b00110, 16'h9A01, 3, 2, 1'b0, 5);
  endtask

  task automatic test_race();
    run_txn("race_last_cycle", 8'hC3, 5'b11001, 16'h7E81, T - 1, 1, 1'b0, 1);
    run_txn("setup_pulse", 8'h42, 5'b01010, 16'h1234, 0, 1, 1'b1, 0);
  endtask

  task automatic test_stuck_done();
    run_txn("stuck_done", 8'h99, 5'b11111, 16'hA5C3, 4, 60, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_i = 8'hA8; cfg_i = 5'b01011; done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (status !== 6'b010111) begin
      errors++; $display("FAIL reset_mid pre status: got %b expected 010111", status);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (status !== 6'b000000 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0 ||
        spi_data_o !== 8'h00 || rsp !== 16'h0000 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got st=%b busy=%b v=%b rdy=%b d=%h rsp=%h err=%b expected zeros",
                         status, busy, rsp_valid, cmd_ready, spi_data_o, rsp, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid release ready/valid: got %b/%b expected 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_txn($sformatf("random%0d", n), 8'($urandom), 5'($urandom), 16'($urandom),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_backpressure();
    test_race();
    test_stuck_done();
    test_reset_mid();
    test_nominal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
